// File: rtl/phase_sweep.sv
// phase_sweep: steps the phase-measurement unit through every antenna channel,
// records the min/max locked phase and publishes a centring phase per sweep.
//
//   state  | meaning
//   IDLE   | waiting for sweep_i
//   SETTLE | select changed, waiting for the measurement MUX to settle
//   ALIGN  | align requested, waiting for lock, invalid or timeout
//   NEXT   | advance select, or finish after the last channel
//   FINISH | publish phase/spread, pulse done
module phase_sweep #(
    parameter int WIDTH  = 24,
    parameter int SBITS  = 5,
    parameter int RBITS  = 4,
    parameter int SETTLE = 4,
    parameter int TBITS  = 12,
    parameter int DELAY  = 3
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             sweep_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [RBITS-1:0] phase_o,
    output logic [RBITS-1:0] spread_o,
    output logic [WIDTH-1:0] fail_o,
    output logic [SBITS-1:0] select_o,
    output logic             align_o,
    output logic             start_o,
    output logic             restart_o,
    input  logic             locked_i,
    input  logic             strobe_i,
    input  logic [RBITS-1:0] phase_i,
    input  logic             invalid_i
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    // DELAY is a simulation-only register delay; this model is zero-delay, so it is only range-checked.
    if (SETTLE < 1 || DELAY < 0 || WIDTH < 1 || TBITS < 1 || (2 ** SBITS) < WIDTH) begin : g_bad_params
        $error("phase_sweep: inconsistent parameters");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ALIGN,
        ST_NEXT,
        ST_FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    settle_q;
    logic [TBITS-1:0] tmo_q;
    logic [RBITS-1:0] min_q, max_q;
    logic             got_lock_q;
    logic [SBITS-1:0] select_q;
    logic [WIDTH-1:0] fail_q;
    logic [RBITS-1:0] phase_q, spread_q;
    logic             start_q, restart_q, done_q;

    logic             sweep_start, capture, chan_fail, restart_now;
    logic             last_chan, tmo_hit;
    logic [RBITS:0]   sum;

    assign last_chan = (select_q == SBITS'(WIDTH - 1));
    // The cycle whose increment would bring the counter to all-ones is the last ALIGN cycle.
    assign tmo_hit   = ((tmo_q + TBITS'(1)) == {TBITS{1'b1}});
    assign sum       = {1'b0, min_q} + {1'b0, max_q};

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sweep_start = 1'b0;
        capture     = 1'b0;
        chan_fail   = 1'b0;
        restart_now = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sweep_i) begin
                    sweep_start = 1'b1;
                    state_d     = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (invalid_i) begin
                    chan_fail   = 1'b1;
                    restart_now = 1'b1;
                    state_d     = ST_NEXT;
                end else if (locked_i && strobe_i) begin
                    capture = 1'b1;
                    state_d = ST_NEXT;
                end else if (tmo_hit) begin
                    chan_fail = 1'b1;
                    state_d   = ST_NEXT;
                end
            end
            ST_NEXT: begin
                state_d = last_chan ? ST_FINISH : ST_SETTLE;
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            settle_q   <= CW'(SETTLE - 1);
            tmo_q      <= '0;
            min_q      <= '1;
            max_q      <= '0;
            got_lock_q <= 1'b0;
            select_q   <= '0;
            fail_q     <= '0;
            phase_q    <= '0;
            spread_q   <= '0;
            start_q    <= 1'b0;
            restart_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            start_q   <= capture && !got_lock_q;
            restart_q <= restart_now;
            done_q    <= (state_q == ST_FINISH);

            if (state_q != ST_SETTLE) begin
                settle_q <= CW'(SETTLE - 1);
            end else if (settle_q != '0) begin
                settle_q <= settle_q - CW'(1);
            end

            if (state_q == ST_ALIGN) begin
                tmo_q <= tmo_q + TBITS'(1);
            end else begin
                tmo_q <= '0;
            end

            if (sweep_start) begin
                fail_q     <= '0;
                min_q      <= '1;
                max_q      <= '0;
                got_lock_q <= 1'b0;
                select_q   <= '0;
            end

            if (capture) begin
                got_lock_q <= 1'b1;
                if (phase_i < min_q) begin
                    min_q <= phase_i;
                end
                if (phase_i > max_q) begin
                    max_q <= phase_i;
                end
            end

            if (chan_fail) begin
                fail_q <= fail_q | (WIDTH'(1) << select_q);
            end

            if (state_q == ST_NEXT && !last_chan) begin
                select_q <= select_q + SBITS'(1);
            end

            // A sweep with no locked channel leaves the previous result in place.
            if (state_q == ST_FINISH && got_lock_q) begin
                phase_q  <= RBITS'(sum >> 1);
                spread_q <= max_q - min_q;
            end
        end
    end

    assign busy_o    = (state_q != ST_IDLE);
    assign align_o   = (state_q == ST_ALIGN);
    assign done_o    = done_q;
    assign start_o   = start_q;
    assign restart_o = restart_q;
    assign select_o  = select_q;
    assign fail_o    = fail_q;
    assign phase_o   = phase_q;
    assign spread_o  = spread_q;

endmodule
